// File: rtl/loop_regs_pkg.sv
// rtl/loop_regs_pkg.sv - shared register map, field widths and helpers for the loop-filter bank
package loop_regs_pkg;

  typedef enum logic [2:0] {
    REG_CONTROL      = 3'd0,
    REG_LEAD_LAG     = 3'd1,
    REG_LIMIT        = 3'd2,
    REG_LOOPOFFSET   = 3'd3,
    REG_FSKTHRESHOLD = 3'd4
  } reg_off_e;

  localparam logic [2:0]  REG_LAST      = 3'd4;
  localparam int          LL_W_DEF      = 5;
  localparam int          TH_W_DEF      = 8;
  localparam int          LEAD_LSB      = 16;
  localparam logic [31:0] LIMIT_RST_DEF = 32'h7FFF_FFFF;

  localparam int CTL_ZERO   = 0;
  localparam int CTL_INVERT = 1;
  localparam int CTL_SLIP   = 2;
  localparam int CTL_APPLY  = 31;

  // Byte-lane merge: each set lane bit replaces the matching byte of old_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/loop_regs_channel.sv
// rtl/loop_regs_channel.sv - one loop-filter channel: shadow/active registers, apply and slip requests
module loop_regs_channel
  import loop_regs_pkg::*;
#(
  parameter int          LL_W      = LL_W_DEF,
  parameter int          TH_W      = TH_W_DEF,
  parameter logic [31:0] LIMIT_RST = LIMIT_RST_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      lanes,
  input  logic [2:0]      reg_sel,
  input  logic [31:0]     data_in,
  input  logic            sample_en,
  output logic [LL_W-1:0] lead,
  output logic [LL_W-1:0] lag,
  output logic [31:0]     limit,
  output logic [31:0]     loop_offset,
  output logic [TH_W-1:0] fsk_threshold,
  output logic            zero_error,
  output logic            invert_error,
  output logic            slip,
  output logic            apply_pending,
  output logic [31:0]     rd_word
);

  logic [LL_W-1:0] lead_sh, lag_sh;
  logic [31:0]     limit_sh, offset_sh;
  logic [TH_W-1:0] th_sh;
  logic            slip_req;

  logic we_ctrl, we_ll, we_limit, we_offset, we_th;
  logic do_apply;

  always_comb begin
    we_ctrl   = (reg_sel == REG_CONTROL);
    we_ll     = (reg_sel == REG_LEAD_LAG);
    we_limit  = (reg_sel == REG_LIMIT);
    we_offset = (reg_sel == REG_LOOPOFFSET);
    we_th     = (reg_sel == REG_FSKTHRESHOLD);
    do_apply  = apply_pending && sample_en;
  end

  // The slip pulse is the request gated by the strobe, so it lines up with sampleEn.
  assign slip = slip_req && sample_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      lead_sh       <= '0;
      lag_sh        <= '0;
      limit_sh      <= LIMIT_RST;
      offset_sh     <= '0;
      th_sh         <= '0;
      lead          <= '0;
      lag           <= '0;
      limit         <= LIMIT_RST;
      loop_offset   <= '0;
      fsk_threshold <= '0;
      zero_error    <= 1'b0;
      invert_error  <= 1'b0;
      slip_req      <= 1'b0;
      apply_pending <= 1'b0;
    end else begin
      if (we_ctrl && lanes[0]) begin
        zero_error   <= data_in[CTL_ZERO];
        invert_error <= data_in[CTL_INVERT];
      end
      slip_req      <= (slip_req && !sample_en) ||
                       (we_ctrl && lanes[0] && data_in[CTL_SLIP]);
      apply_pending <= (apply_pending && !sample_en) ||
                       (we_ctrl && lanes[3] && data_in[CTL_APPLY]);

      // Transfer reads the pre-write shadow; a same-clk write still lands in shadow.
      if (do_apply) begin
        lead          <= lead_sh;
        lag           <= lag_sh;
        limit         <= limit_sh;
        loop_offset   <= offset_sh;
        fsk_threshold <= th_sh;
      end

      if (we_ll && lanes[0]) lag_sh  <= data_in[LL_W-1:0];
      if (we_ll && lanes[2]) lead_sh <= data_in[LEAD_LSB +: LL_W];
      if (we_limit)          limit_sh  <= merge_lanes(limit_sh, data_in, lanes);
      if (we_offset)         offset_sh <= merge_lanes(offset_sh, data_in, lanes);
      if (we_th && lanes[0]) th_sh <= data_in[TH_W-1:0];
    end
  end

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      REG_CONTROL: begin
        rd_word[CTL_ZERO]   = zero_error;
        rd_word[CTL_INVERT] = invert_error;
        rd_word[CTL_SLIP]   = slip_req;
        rd_word[CTL_APPLY]  = apply_pending;
      end
      REG_LEAD_LAG:     rd_word = (32'(lead_sh) << LEAD_LSB) | 32'(lag_sh);
      REG_LIMIT:        rd_word = limit_sh;
      REG_LOOPOFFSET:   rd_word = offset_sh;
      REG_FSKTHRESHOLD: rd_word = 32'(th_sh);
      default:          rd_word = '0;
    endcase
  end

endmodule

// File: rtl/multi_loop_regs.sv
// rtl/multi_loop_regs.sv - loop-filter register bank top: address/lane decode, channels, readback
module multi_loop_regs
  import loop_regs_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter logic [11:0] BASE_ADDR = 12'h400,
  parameter int          LL_W      = LL_W_DEF,
  parameter int          TH_W      = TH_W_DEF,
  parameter logic [31:0] LIMIT_RST = LIMIT_RST_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cs,
  input  logic [11:0]            addr,
  input  logic [31:0]            dataIn,
  input  logic                   wr0,
  input  logic                   wr1,
  input  logic                   wr2,
  input  logic                   wr3,
  input  logic                   sampleEn,
  output logic [31:0]            dataOut,
  output logic [NUM_CH-1:0]      zeroError,
  output logic [NUM_CH-1:0]      invertError,
  output logic [NUM_CH-1:0]      slip,
  output logic [LL_W*NUM_CH-1:0] lead,
  output logic [LL_W*NUM_CH-1:0] lag,
  output logic [32*NUM_CH-1:0]   limit,
  output logic [32*NUM_CH-1:0]   loopOffset,
  output logic [TH_W*NUM_CH-1:0] fskThreshold,
  output logic [NUM_CH-1:0]      applyPending
);

  logic [2:0]  ch;
  logic [2:0]  reg_sel;
  logic [3:0]  lanes;
  logic        hit;
  logic [31:0] rd_words [8];
  logic        unused_addr;

  assign ch          = addr[7:5];
  assign reg_sel     = addr[4:2];
  assign lanes       = {wr3, wr2, wr1, wr0};
  assign unused_addr = ^addr[1:0];

  // Same decode gates both writes and readback, so misses always read 0.
  assign hit = cs && (addr[11:8] == BASE_ADDR[11:8]) &&
               ({1'b0, ch} < 4'(NUM_CH)) && (reg_sel <= REG_LAST);

  for (genvar i = 0; i < 8; i++) begin : g_ch
    if (i < NUM_CH) begin : g_live
      logic [3:0] ch_lanes;
      assign ch_lanes = (hit && ch == 3'(i)) ? lanes : 4'b0000;

      loop_regs_channel #(
        .LL_W      (LL_W),
        .TH_W      (TH_W),
        .LIMIT_RST (LIMIT_RST)
      ) u_ch (
        .clk           (clk),
        .reset         (reset),
        .lanes         (ch_lanes),
        .reg_sel       (reg_sel),
        .data_in       (dataIn),
        .sample_en     (sampleEn),
        .lead          (lead[i*LL_W +: LL_W]),
        .lag           (lag[i*LL_W +: LL_W]),
        .limit         (limit[i*32 +: 32]),
        .loop_offset   (loopOffset[i*32 +: 32]),
        .fsk_threshold (fskThreshold[i*TH_W +: TH_W]),
        .zero_error    (zeroError[i]),
        .invert_error  (invertError[i]),
        .slip          (slip[i]),
        .apply_pending (applyPending[i]),
        .rd_word       (rd_words[i])
      );
    end else begin : g_absent
      assign rd_words[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dataOut <= '0;
    end else begin
      dataOut <= hit ? rd_words[ch] : '0;
    end
  end

endmodule

// File: tb/tb_multi_loop_regs.sv
// tb/tb_multi_loop_regs.sv - scoreboard bench for multi_loop_regs
module tb_multi_loop_regs;

  localparam int NUM_CH = 4;
  localparam int LL_W   = 5;
  localparam int TH_W   = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   cs;
  logic [11:0]            addr;
  logic [31:0]            dataIn;
  logic                   wr0, wr1, wr2, wr3;
  logic                   sampleEn;
  logic [31:0]            dataOut;
  logic [NUM_CH-1:0]      zeroError, invertError, slip, applyPending;
  logic [LL_W*NUM_CH-1:0] lead, lag;
  logic [32*NUM_CH-1:0]   limit, loopOffset;
  logic [TH_W*NUM_CH-1:0] fskThreshold;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb [$];

  multi_loop_regs #(.NUM_CH(NUM_CH), .BASE_ADDR(12'h400), .LL_W(LL_W), .TH_W(TH_W),
                    .LIMIT_RST(32'h7FFF_FFFF)) dut (
    .clk(clk), .reset(reset), .cs(cs), .addr(addr), .dataIn(dataIn),
    .wr0(wr0), .wr1(wr1), .wr2(wr2), .wr3(wr3), .sampleEn(sampleEn),
    .dataOut(dataOut), .zeroError(zeroError), .invertError(invertError), .slip(slip),
    .lead(lead), .lag(lag), .limit(limit), .loopOffset(loopOffset),
    .fskThreshold(fskThreshold), .applyPending(applyPending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle; strobes and sampleEn last exactly one clk.
  task automatic bus(input logic c, input int chn, input int rg, input logic [31:0] d,
                     input logic [3:0] ln, input logic smp);
    cs       = c;
    addr     = {4'h4, 3'(chn), 3'(rg), 2'b00};
    dataIn   = d;
    {wr3, wr2, wr1, wr0} = ln;
    sampleEn = smp;
    tick();
    cs = 1'b0;
    {wr3, wr2, wr1, wr0} = 4'b0000;
    sampleEn = 1'b0;
  endtask

  task automatic rd(input string tag, input logic c, input int chn, input int rg,
                    input logic [31:0] exp);
    sb.push_back(exp);
    bus(c, chn, rg, 32'h0, 4'b0000, 1'b0);
    if (sb.size() == 0) check({tag, "_sb_empty"}, 32'h1, 32'h0);
    else check(tag, dataOut, sb.pop_front());
  endtask

  task automatic sample();
    bus(1'b0, 0, 0, 32'h0, 4'b0000, 1'b1);
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; addr = '0; dataIn = '0;
    {wr3, wr2, wr1, wr0} = 4'b0000; sampleEn = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    for (int i = 0; i < NUM_CH; i++) check($sformatf("rst_limit%0d", i), limit[32*i +: 32], 32'h7FFF_FFFF);
    check("rst_offset", loopOffset[31:0] | loopOffset[63:32] | loopOffset[95:64] | loopOffset[127:96], 32'h0);
    check("rst_leadlag", 32'({lead, lag}), 32'h0);
    check("rst_fsk", fskThreshold, 32'h0);
    check("rst_flags", {16'h0, zeroError, invertError, slip, applyPending}, 32'h0);
    check("rst_dataout", dataOut, 32'h0);
    rd("rst_rd_limit2", 1'b1, 2, 2, 32'h7FFF_FFFF);

    // Shadow write with no apply leaves active untouched
    bus(1'b1, 1, 2, 32'h0001_2345, 4'b1111, 1'b0);
    sample(); sample(); sample();
    check("noapply_limit1", limit[63:32], 32'h7FFF_FFFF);
    rd("shadow_limit1", 1'b1, 1, 2, 32'h0001_2345);

    // Arm then sample
    bus(1'b1, 1, 0, 32'h8000_0000, 4'b1000, 1'b0);
    check("armed1", 32'(applyPending), 32'h2);
    rd("ctrl1_armed", 1'b1, 1, 0, 32'h8000_0000);
    sample();
    check("apply_limit1", limit[63:32], 32'h0001_2345);
    check("apply_clr1", 32'(applyPending), 32'h0);
    check("apply_other0", limit[31:0], 32'h7FFF_FFFF);

    // Arm in same clk as sampleEn waits; newest shadow transferred
    bus(1'b1, 3, 0, 32'h8000_0000, 4'b1000, 1'b1);
    check("samecyc_pending3", 32'(applyPending), 32'h8);
    check("samecyc_lag3", 32'(lag[3*LL_W +: LL_W]), 32'h0);
    bus(1'b1, 3, 1, 32'h0015_001F, 4'b0101, 1'b0);
    check("pendwr_lag3", 32'(lag[3*LL_W +: LL_W]), 32'h0);
    rd("rd_leadlag3", 1'b1, 3, 1, 32'h0015_001F);
    sample();
    check("xfer_lag3", 32'(lag[3*LL_W +: LL_W]), 32'h1F);
    check("xfer_lead3", 32'(lead[3*LL_W +: LL_W]), 32'h15);

    // Same-clk shadow write and transfer
    bus(1'b1, 0, 2, 32'h1111_1111, 4'b1111, 1'b0);
    bus(1'b1, 0, 0, 32'h8000_0000, 4'b1000, 1'b0);
    bus(1'b1, 0, 2, 32'h2222_2222, 4'b1111, 1'b1);
    check("race_active0", limit[31:0], 32'h1111_1111);
    check("race_pending", 32'(applyPending), 32'h0);
    rd("race_shadow0", 1'b1, 0, 2, 32'h2222_2222);

    // Slip request and immediate control bits
    bus(1'b1, 2, 0, 32'h0000_0004, 4'b0001, 1'b0);
    check("slip_idle", 32'(slip), 32'h0);
    rd("slipreq_rd", 1'b1, 2, 0, 32'h0000_0004);
    sampleEn = 1'b1;
    #1;
    check("slip_pulse", 32'(slip), 32'h4);
    tick();
    sampleEn = 1'b0;
    check("slip_after", 32'(slip), 32'h0);
    rd("slipreq_clr", 1'b1, 2, 0, 32'h0);
    sampleEn = 1'b1;
    #1;
    check("slip_once", 32'(slip), 32'h0);
    tick();
    sampleEn = 1'b0;
    bus(1'b1, 0, 0, 32'h0000_0003, 4'b0001, 1'b0);
    check("zero_err", 32'(zeroError), 32'h1);
    check("inv_err", 32'(invertError), 32'h1);
    rd("ctrl0_rd", 1'b1, 0, 0, 32'h0000_0003);

    // Byte lanes, fsk, misses
    bus(1'b1, 0, 3, 32'hAABB_CCDD, 4'b0100, 1'b0);
    rd("lane2_offset0", 1'b1, 0, 3, 32'h00BB_0000);
    check("lane2_active0", loopOffset[31:0], 32'h0);
    bus(1'b1, 1, 4, 32'hFFFF_FF23, 4'b1111, 1'b0);
    rd("fsk1_rd", 1'b1, 1, 4, 32'h0000_0023);
    bus(1'b1, 7, 2, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    rd("ch7_rd", 1'b1, 7, 2, 32'h0);
    rd("reg5_rd", 1'b1, 0, 5, 32'h0);
    rd("nocs_rd", 1'b0, 0, 2, 32'h0);
    check("ch7_no_side", limit[127:96], 32'h7FFF_FFFF);

    // Reset while pending discards the apply
    bus(1'b1, 2, 2, 32'h0000_0055, 4'b1111, 1'b0);
    bus(1'b1, 2, 0, 32'h8000_0000, 4'b1000, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_pend_clr", 32'(applyPending), 32'h0);
    sample();
    check("rst_pend_limit2", limit[95:64], 32'h7FFF_FFFF);
    rd("rst_shadow2", 1'b1, 2, 2, 32'h7FFF_FFFF);

    if (sb.size() != 0) check("sb_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
